exe_muldiv: RTL and testbench
=============================

EXE_MULDIV -- requirements
Module: exe_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width; legal values are even and at least 8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-low reset; the design SHALL reset when rst is sampled 0 on a clk edge.
REQ-004 SHALL have port I_valid  input  1  request present.
REQ-005 SHALL have port O_ready  output  1  unit idle and able to accept a request.
REQ-006 SHALL have port I_op  input  3  RV-M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port I_srca  input  XLEN  rs1 operand.
REQ-008 SHALL have port I_srcb  input  XLEN  rs2 operand.
REQ-009 SHALL have port I_annul  input  1  flush: abandon any operation in progress.
REQ-010 SHALL have port O_valid  output  1  O_result holds a finished result.
REQ-011 SHALL have port I_ack  input  1  consumer takes the result.
REQ-012 SHALL have port O_result  output  XLEN  result per I_op.

Function
REQ-013 SHALL implement a four-state FSM: IDLE, MUL, DIV, DONE; O_ready = (state==IDLE).
REQ-014 SHALL accept a request in cycle t when I_valid && O_ready && !I_annul; SHALL latch I_op, I_srca and I_srcb at t and ignore later changes on those inputs.
REQ-015 SHALL, in MUL, run an XLEN-iteration shift-add on operand magnitudes.
REQ-016 SHALL take operand signedness from I_op: MUL and MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned.
REQ-017 SHALL form the 2*XLEN product; MUL returns the low half and the MULH* ops return the high half.
REQ-018 SHALL, in DIV, run an XLEN-iteration restoring division on magnitudes.
REQ-019 SHALL give the quotient the sign of (dividend XOR divisor) and the remainder the sign of the dividend.
REQ-020 SHALL, for normal ops, enter DONE and assert O_valid at cycle t+XLEN+1, with sign correction applied on entry to DONE.
REQ-021 SHALL treat divide-by-zero as a fast path: DONE at t+1, quotient all-ones, remainder = dividend (signed and unsigned).
REQ-022 SHALL treat signed overflow (DIV/REM of the most-negative value by -1) as a fast path: DONE at t+1, quotient = dividend, remainder 0.
REQ-023 SHALL hold O_valid and O_result stable in DONE until I_ack is sampled high, then return to IDLE next cycle.
REQ-024 SHALL NOT accept a new request in the same cycle as the I_ack that ends DONE.
REQ-025 SHALL ignore I_ack while O_valid is 0.
REQ-026 SHALL, on I_annul in any state, go to IDLE next cycle, deassert O_valid, and never present the abandoned result.
REQ-027 SHALL give I_annul priority over I_ack and over I_valid.
REQ-028 SHALL drive O_result = 0 whenever O_valid = 0.

Reset
REQ-029 SHALL, on reset, set state=IDLE, O_valid=0, O_result=0 (so O_ready=1) and clear all iteration counters and datapath registers.
REQ-030 SHALL, when reset occurs mid-operation, discard the operation with no result presented.

Configuration
REQ-031 SHALL support macro MULDIV_FAST_MUL_EN.
REQ-032 SHALL, when MULDIV_FAST_MUL_EN is defined, compute all multiply ops in one cycle with a 2*XLEN combinational product, MUL state unused, O_valid at t+1.
REQ-033 SHALL, when MULDIV_FAST_MUL_EN is undefined, use the iterative multiplier per REQ-015..REQ-017 with latency XLEN+1.
REQ-034 SHALL keep divide behaviour identical with or without MULDIV_FAST_MUL_EN.

Structure
REQ-035 SHALL take the I_op encodings (MULDIV_OP_*) and FSM state encodings from the shared defines file.
REQ-036 SHALL implement the restoring divider as one sub-module, muldiv_div_core: unsigned magnitudes in, quotient and remainder out, XLEN-cycle start/done.
REQ-037 SHALL keep the sign handling, fast-path detection and FSM in exe_muldiv.

Verification
REQ-038 SHALL check, at XLEN=32 without the macro: MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB with O_valid at t+33; MULH 0x80000000 x 0x80000000 -> 0x40000000.
REQ-039 SHALL check MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF and MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-040 SHALL check DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14 at t+33.
REQ-041 SHALL check DIVU 5/0 -> 0xFFFFFFFF at t+1; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, both at t+1.
REQ-042 SHALL check I_annul at iteration 10 of a DIV: O_valid never rises, O_ready=1 next cycle, and a following MUL 3x4 -> 12.
REQ-043 SHALL check I_ack held low 5 cycles in DONE with O_result stable, and rst=0 mid-MUL giving O_valid=0, O_ready=1, O_result=0 after the reset edge.

Source files
------------

// File: rtl/exe_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// exe_muldiv_pkg
//   Shared definitions for the RV-M multiply/divide unit:
//     - MULDIV_OP_* : funct3 encodings carried on I_op
//     - muldiv_state_e : FSM state encoding (also exported for debug)
//     - small decode helpers used by the top-level FSM/datapath
//   No ports (package).
// ---------------------------------------------------------------------------
package exe_muldiv_pkg;

    localparam logic [2:0] MULDIV_OP_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_OP_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_OP_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_OP_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_OP_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_OP_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_OP_REM    = 3'b110;
    localparam logic [2:0] MULDIV_OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    // Bit 2 of funct3 separates the divide group from the multiply group.
    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // REM / REMU return the remainder rather than the quotient.
    function automatic logic op_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    // MULH, MULHSU, MULHU return the upper half of the product.
    function automatic logic op_high_half(input logic [2:0] op);
        return (op[1:0] != 2'b00);
    endfunction

    // rs1 is signed for MUL, MULH, MULHSU, DIV, REM.
    function automatic logic op_signed_a(input logic [2:0] op);
        if (op[2]) return ~op[0];
        return (op[1:0] != 2'b11);
    endfunction

    // rs2 is signed for MUL, MULH, DIV, REM.
    function automatic logic op_signed_b(input logic [2:0] op);
        if (op[2]) return ~op[0];
        return ~op[1];
    endfunction

endpackage

// File: rtl/exe_muldiv_if.sv
// ---------------------------------------------------------------------------
// exe_muldiv_if
//   Request/response bundle of the multiply/divide unit.
//   Signals:
//     I_valid, I_op[2:0], I_srca, I_srcb : request from the issuing stage
//     O_ready                            : unit idle, request can be taken
//     I_annul                            : flush, abandons any operation
//     O_valid, O_result                  : finished result
//     I_ack                              : consumer takes the result
//     dbg_state                          : current FSM state (observation only)
//
//   Handshake: a request transfers on a rising edge where
//   I_valid && O_ready && !I_annul; the operands are captured on that edge.
//   A result transfers on a rising edge where O_valid && I_ack; O_valid and
//   O_result stay stable until then. I_ack is ignored while O_valid is low.
//   I_annul wins over both handshakes and drops the unit back to idle.
//
//   master : issuing stage side        slave : the unit (exe_muldiv)
// ---------------------------------------------------------------------------
interface exe_muldiv_if #(
    parameter int XLEN = 32
);
    import exe_muldiv_pkg::*;

    logic            I_valid;
    logic            O_ready;
    logic [2:0]      I_op;
    logic [XLEN-1:0] I_srca;
    logic [XLEN-1:0] I_srcb;
    logic            I_annul;
    logic            O_valid;
    logic            I_ack;
    logic [XLEN-1:0] O_result;
    muldiv_state_e   dbg_state;

    modport master (
        output I_valid, I_op, I_srca, I_srcb, I_annul, I_ack,
        input  O_ready, O_valid, O_result, dbg_state
    );

    modport slave (
        input  I_valid, I_op, I_srca, I_srcb, I_annul, I_ack,
        output O_ready, O_valid, O_result, dbg_state
    );

endinterface

// File: rtl/exe_muldiv_div_core.sv
// ---------------------------------------------------------------------------
// muldiv_div_core
//   Unsigned restoring divider, one quotient bit per cycle, XLEN cycles.
//   Ports:
//     clk, rst            : clock, synchronous active-low reset
//     start               : load dividend/divisor and begin (one-cycle pulse)
//     abort               : drop the division in progress
//     dividend, divisor   : unsigned magnitudes (divisor must be non-zero)
//     done                : high during the last iteration cycle
//     quotient, remainder : final values, valid while done is high
//   The outputs are the combinational result of the current iteration, so
//   on the done cycle they already hold the completed quotient/remainder.
// ---------------------------------------------------------------------------
module muldiv_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] quo_q;   // dividend bits shift out of the top, quotient bits in at the bottom
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dsr_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;

    logic [XLEN:0]   trial;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] quo_n;
    logic [XLEN-1:0] rem_n;

    // Since rem_q < divisor, trial < 2*divisor; if trial does not fit in
    // XLEN bits the subtraction always succeeds, so the restored value
    // never loses its top bit.
    always_comb begin
        trial = {rem_q, quo_q[XLEN-1]};
        diff  = trial - {1'b0, dsr_q};
        if (diff[XLEN]) begin
            rem_n = trial[XLEN-1:0];
            quo_n = {quo_q[XLEN-2:0], 1'b0};
        end else begin
            rem_n = diff[XLEN-1:0];
            quo_n = {quo_q[XLEN-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (abort) begin
            busy_q <= 1'b0;
        end else if (start) begin
            quo_q  <= dividend;
            rem_q  <= '0;
            dsr_q  <= divisor;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            quo_q <= quo_n;
            rem_q <= rem_n;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN - 1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done      = busy_q && (cnt_q == CW'(XLEN - 1));
    assign quotient  = quo_n;
    assign remainder = rem_n;

endmodule

// File: rtl/exe_muldiv.sv
// ---------------------------------------------------------------------------
// exe_muldiv
//   RV-M multiply/divide execution unit.
//   Ports:
//     clk  : clock, all state on the rising edge
//     rst  : synchronous active-low reset
//     bus  : exe_muldiv_if.slave (request, annul, result, ack, dbg_state)
//   Parameter XLEN : operand/result width (even, >= 8).
//
//   Multiplies run an XLEN-step shift-add on operand magnitudes; divides use
//   muldiv_div_core on magnitudes. Signs are restored when the result is
//   written on entry to DONE. Divide-by-zero and signed overflow bypass the
//   divider and finish one cycle after acceptance.
//
//   Configuration macro MULDIV_FAST_MUL_EN: when defined, all multiplies are
//   computed in the acceptance cycle with a combinational 2*XLEN product and
//   the MUL state is never entered. Divides are unaffected.
// ---------------------------------------------------------------------------
module exe_muldiv
    import exe_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    exe_muldiv_if.slave  bus
);

    localparam int              CW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // ---------------- state and datapath registers ----------------
    muldiv_state_e   state_q, state_d;
    logic [2:0]      op_q;
    logic            neg_prod_q;   // product / quotient must be negated
    logic            neg_rem_q;    // remainder must be negated (dividend sign)
    logic [XLEN-1:0] hi_q;         // upper half of the running product
    logic [XLEN-1:0] lo_q;         // multiplier bits, replaced by product bits
    logic [XLEN-1:0] mcand_q;
    logic [CW-1:0]   mul_cnt_q;
    logic [XLEN-1:0] res_q;

    // ---------------- request decode ----------------
    logic            in_sa, in_sb;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf;
    logic            req_fast;
    logic [XLEN-1:0] fast_res;
    logic            accept;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
`endif

    always_comb begin
        in_sa    = op_signed_a(bus.I_op);
        in_sb    = op_signed_b(bus.I_op);
        a_neg    = in_sa & bus.I_srca[XLEN-1];
        b_neg    = in_sb & bus.I_srcb[XLEN-1];
        a_mag    = a_neg ? -bus.I_srca : bus.I_srca;
        b_mag    = b_neg ? -bus.I_srcb : bus.I_srcb;
        div_zero = (bus.I_srcb == '0);
        div_ovf  = in_sa && (bus.I_srca == MIN_NEG) && (bus.I_srcb == '1);
        req_fast = 1'b0;
        fast_res = '0;
`ifdef MULDIV_FAST_MUL_EN
        fast_prod = '0;
`endif
        if (op_is_div(bus.I_op)) begin
            if (div_zero) begin
                req_fast = 1'b1;
                fast_res = op_is_rem(bus.I_op) ? bus.I_srca : '1;
            end else if (div_ovf) begin
                req_fast = 1'b1;
                fast_res = op_is_rem(bus.I_op) ? '0 : bus.I_srca;
            end
        end
`ifdef MULDIV_FAST_MUL_EN
        else begin
            fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
            if (a_neg ^ b_neg) begin
                fast_prod = -fast_prod;
            end
            req_fast = 1'b1;
            fast_res = op_high_half(bus.I_op) ? fast_prod[2*XLEN-1:XLEN]
                                              : fast_prod[XLEN-1:0];
        end
`endif
    end

    assign accept = bus.I_valid && (state_q == ST_IDLE) && !bus.I_annul;

    // ---------------- iterative multiplier step ----------------
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   hi_n, lo_n;
    logic [2*XLEN-1:0] prod_n;
    logic [XLEN-1:0]   mul_res;
    logic              mul_last;

    // Each step adds the multiplicand into the upper half when the current
    // multiplier bit is set, then shifts {carry, hi, lo} right by one.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        hi_n     = mul_sum[XLEN:1];
        lo_n     = {mul_sum[0], lo_q[XLEN-1:1]};
        prod_n   = {hi_n, lo_n};
        if (neg_prod_q) begin
            prod_n = -prod_n;
        end
        mul_res  = op_high_half(op_q) ? prod_n[2*XLEN-1:XLEN] : prod_n[XLEN-1:0];
        mul_last = (state_q == ST_MUL) && (mul_cnt_q == CW'(XLEN - 1));
    end

    // ---------------- divider ----------------
    logic            div_start, div_done;
    logic [XLEN-1:0] div_quo, div_rem, div_res;

    assign div_start = accept && op_is_div(bus.I_op) && !req_fast;

    muldiv_div_core #(.XLEN(XLEN)) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (bus.I_annul),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign div_res = op_is_rem(op_q) ? (neg_rem_q  ? -div_rem : div_rem)
                                     : (neg_prod_q ? -div_quo : div_quo);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    logic o_ready, o_valid;

    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (bus.I_valid) begin
                    if (req_fast)                    state_d = ST_DONE;
                    else if (op_is_div(bus.I_op))    state_d = ST_DIV;
                    else                             state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                if (mul_last) state_d = ST_DONE;
            end
            ST_DIV: begin
                if (div_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                o_valid = 1'b1;
                if (bus.I_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Annul overrides every transition, including acceptance and ack.
        if (bus.I_annul) begin
            state_d = ST_IDLE;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q       <= '0;
            neg_prod_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            mcand_q    <= '0;
            mul_cnt_q  <= '0;
            res_q      <= '0;
        end else if (accept) begin
            op_q       <= bus.I_op;
            neg_prod_q <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            hi_q       <= '0;
            lo_q       <= b_mag;
            mcand_q    <= a_mag;
            mul_cnt_q  <= '0;
            // Only meaningful for fast paths; iterative ops overwrite it.
            res_q      <= fast_res;
        end else if (!bus.I_annul) begin
            if (state_q == ST_MUL) begin
                hi_q      <= hi_n;
                lo_q      <= lo_n;
                mul_cnt_q <= mul_cnt_q + CW'(1);
                if (mul_last) begin
                    res_q <= mul_res;
                end
            end
            if (state_q == ST_DIV && div_done) begin
                res_q <= div_res;
            end
        end
    end

    assign bus.O_ready   = o_ready;
    assign bus.O_valid   = o_valid;
    assign bus.O_result  = o_valid ? res_q : '0;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// ---------------------------------------------------------------------------
// tb_exe_muldiv
//   Directed bench for exe_muldiv at XLEN=32. A reference model computes
//   each result with 64-bit arithmetic and tracks when the result must be
//   visible; a compare process checks O_ready/O_valid/O_result against it
//   on every falling edge. Directed vectors also carry literal expectations.
// ---------------------------------------------------------------------------
module tb_exe_muldiv;
    import exe_muldiv_pkg::*;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    exe_muldiv_if #(.XLEN(XLEN)) bus ();

    exe_muldiv #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint    sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = '0;
        case (op)
            MULDIV_OP_MUL:    begin p = sa * sb; return p[31:0];  end
            MULDIV_OP_MULH:   begin p = sa * sb; return p[63:32]; end
            MULDIV_OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            MULDIV_OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            MULDIV_OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            MULDIV_OP_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            MULDIV_OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2]) begin
            if (b == 0) return 1;
            if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return DIV_LAT;
        end
        return MUL_LAT;
    endfunction

    // Model of what the unit must show: results waiting in exp_q, a cycle
    // countdown until the head result becomes visible.
    logic [31:0] exp_q[$];
    bit m_busy  = 1'b0;
    bit m_valid = 1'b0;
    int m_wait  = 0;

    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 0; m_valid = 0; m_wait = 0; exp_q.delete();
        end else if (bus.I_annul) begin
            m_busy = 0; m_valid = 0; m_wait = 0; exp_q.delete();
        end else if (m_valid) begin
            if (bus.I_ack) begin
                m_valid = 0;
                void'(exp_q.pop_front());
            end
        end else if (m_busy) begin
            m_wait--;
            if (m_wait == 0) begin m_busy = 0; m_valid = 1; end
        end else if (bus.I_valid) begin
            int lat;
            exp_q.push_back(ref_result(bus.I_op, bus.I_srca, bus.I_srcb));
            lat = ref_latency(bus.I_op, bus.I_srca, bus.I_srcb);
            if (lat == 1) m_valid = 1;
            else begin m_busy = 1; m_wait = lat - 1; end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (checking) begin
            logic [31:0] er;
            er = (m_valid && exp_q.size() > 0) ? exp_q[0] : 32'd0;
            chk("cmp_ready",  {31'd0, bus.O_ready}, {31'd0, !m_busy && !m_valid});
            chk("cmp_valid",  {31'd0, bus.O_valid}, {31'd0, m_valid});
            chk("cmp_result", bus.O_result, er);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    // Waits for O_ready, presents one request for one cycle, returns in t+1
    // with the request inputs scrambled.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!bus.O_ready && n < 100) begin step(); n++; end
        if (n >= 100) chk("issue_ready_timeout", 32'd0, 32'd1);
        bus.I_valid = 1'b1; bus.I_op = op; bus.I_srca = a; bus.I_srcb = b;
        step();
        bus.I_valid = 1'b0;
        bus.I_op    = 3'($urandom_range(0, 7));
        bus.I_srca  = $urandom;
        bus.I_srcb  = $urandom;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit has_lit,
                          input int exp_lat, input int ack_delay, input bit ack_busy,
                          input bit ack_with_req);
        int lat;
        logic [31:0] r0;
        issue(op, a, b);
        bus.I_ack = ack_busy;
        lat = 1;
        while (!bus.O_valid && lat < 100) begin step(); lat++; end
        bus.I_ack = 1'b0;
        if (!bus.O_valid) begin
            chk({name, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({name, "_res"}, bus.O_result, exp);
        if (has_lit) chk({name, "_model"}, ref_result(op, a, b), exp);
        r0 = bus.O_result;
        for (int i = 0; i < ack_delay; i++) begin
            step();
            chk({name, "_hold_valid"}, {31'd0, bus.O_valid}, 32'd1);
            chk({name, "_hold_res"}, bus.O_result, r0);
        end
        bus.I_ack = 1'b1;
        if (ack_with_req) begin
            bus.I_valid = 1'b1; bus.I_op = MULDIV_OP_DIVU; bus.I_srca = 32'd5; bus.I_srcb = 32'd0;
        end
        step();
        bus.I_ack = 1'b0; bus.I_valid = 1'b0;
        chk({name, "_ack_ready"}, {31'd0, bus.O_ready}, 32'd1);
        chk({name, "_ack_valid"}, {31'd0, bus.O_valid}, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.I_valid = 0; bus.I_op = '0; bus.I_srca = '0; bus.I_srcb = '0;
        bus.I_annul = 0; bus.I_ack = 0;
        rst = 1'b0;
        step();
        checking = 1'b1;
        step(); step();
        chk("reset_ready",  {31'd0, bus.O_ready}, 32'd1);
        chk("reset_valid",  {31'd0, bus.O_valid}, 32'd0);
        chk("reset_result", bus.O_result, 32'd0);
        rst = 1'b1;
        step();

        // Multiplies
        run_op("mul_7_m3",     MULDIV_OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, MUL_LAT, 0, 1, 0);
        run_op("mulh_min",     MULDIV_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1, MUL_LAT, 0, 0, 0);
        run_op("mulhsu_ones",  MULDIV_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, MUL_LAT, 0, 0, 0);
        run_op("mulhu_ones",   MULDIV_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, MUL_LAT, 0, 0, 0);
        run_op("mul_min_lo",   MULDIV_OP_MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, MUL_LAT, 0, 0, 0);

        // Divides
        run_op("div_m7_2",     MULDIV_OP_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1, DIV_LAT, 0, 1, 0);
        run_op("rem_m7_2",     MULDIV_OP_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1, DIV_LAT, 0, 0, 0);
        run_op("divu_100_7",   MULDIV_OP_DIVU,   32'd100,      32'd7,        32'd14,        1, DIV_LAT, 0, 0, 0);
        run_op("remu_100_7",   MULDIV_OP_REMU,   32'd100,      32'd7,        32'd2,         1, DIV_LAT, 0, 0, 0);
        run_op("div_7_m2",     MULDIV_OP_DIV,    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 1, DIV_LAT, 0, 0, 0);
        run_op("rem_7_m2",     MULDIV_OP_REM,    32'd7,        32'hFFFF_FFFE, 32'd1,         1, DIV_LAT, 0, 0, 0);
        run_op("div_min_1",    MULDIV_OP_DIV,    32'h8000_0000, 32'd1,        32'h8000_0000, 1, DIV_LAT, 0, 0, 0);
        run_op("divu_max_1",   MULDIV_OP_DIVU,   32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 1, DIV_LAT, 0, 0, 0);

        // Fast paths; the first also tries a new request during the ack cycle
        run_op("divu_5_0",     MULDIV_OP_DIVU,   32'd5,        32'd0,        32'hFFFF_FFFF, 1, 1, 0, 0, 1);
        run_op("rem_5_0",      MULDIV_OP_REM,    32'd5,        32'd0,        32'd5,         1, 1, 0, 0, 0);
        run_op("div_ovf",      MULDIV_OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1, 0, 0, 0);
        run_op("rem_ovf",      MULDIV_OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 1, 0, 0, 0);
        run_op("divu_ovf_pat", MULDIV_OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, DIV_LAT, 0, 0, 0);

        // Result held while I_ack stays low for 5 cycles
        run_op("hold_mulhu",   MULDIV_OP_MULHU,  32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 1, MUL_LAT, 5, 0, 0);

        // Annul at iteration 10 of a DIV, then a MUL
        begin
            bit saw = 0;
            issue(MULDIV_OP_DIV, 32'd1000, 32'd3);
            repeat (9) step();
            bus.I_annul = 1'b1;
            step();
            bus.I_annul = 1'b0;
            chk("annul_div_ready", {31'd0, bus.O_ready}, 32'd1);
            chk("annul_div_valid", {31'd0, bus.O_valid}, 32'd0);
            repeat (40) begin step(); if (bus.O_valid) saw = 1; end
            chk("annul_div_never_valid", {31'd0, saw}, 32'd0);
        end
        run_op("mul_3_4",      MULDIV_OP_MUL,    32'd3,        32'd4,        32'd12,        1, MUL_LAT, 0, 0, 0);

        // Annul while a result is presented
        issue(MULDIV_OP_REMU, 32'd9, 32'd0);
        chk("annul_done_pre_valid", {31'd0, bus.O_valid}, 32'd1);
        bus.I_annul = 1'b1;
        step();
        bus.I_annul = 1'b0;
        chk("annul_done_valid",  {31'd0, bus.O_valid}, 32'd0);
        chk("annul_done_result", bus.O_result, 32'd0);
        chk("annul_done_ready",  {31'd0, bus.O_ready}, 32'd1);

        // Annul beats I_valid in IDLE
        bus.I_valid = 1'b1; bus.I_annul = 1'b1;
        bus.I_op = MULDIV_OP_DIVU; bus.I_srca = 32'd5; bus.I_srcb = 32'd0;
        step();
        bus.I_valid = 1'b0; bus.I_annul = 1'b0;
        chk("annul_idle_valid", {31'd0, bus.O_valid}, 32'd0);
        chk("annul_idle_ready", {31'd0, bus.O_ready}, 32'd1);

        // Reset in the middle of a multiply
        begin
            bit saw = 0;
            issue(MULDIV_OP_MUL, 32'd123, 32'd456);
            repeat (5) step();
            rst = 1'b0;
            step();
            rst = 1'b1;
            chk("rst_mid_valid",  {31'd0, bus.O_valid}, 32'd0);
            chk("rst_mid_ready",  {31'd0, bus.O_ready}, 32'd1);
            chk("rst_mid_result", bus.O_result, 32'd0);
            repeat (40) begin step(); if (bus.O_valid) saw = 1; end
            chk("rst_mid_never_valid", {31'd0, saw}, 32'd0);
        end

        // Model-checked vectors across all ops, some with a zero divisor
        for (int i = 0; i < 16; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'(i % 8);
            a  = $urandom;
            b  = (i % 5 == 0) ? 32'd0 : $urandom;
            run_op("sweep", op, a, b, ref_result(op, a, b), 0, ref_latency(op, a, b),
                   $urandom_range(0, 2), 0, 0);
        end

        step();
        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
